// File: rtl/ceas_pkg.sv
// Shared definitions for the random-key Caesar encryptor/decryptor pair.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Contents: LFSR tap mask and step, alphabet constants, stream FSM states, decrypt helper.
package ceas_pkg;

    // Fibonacci taps 32,22,2,1 expressed as a bit mask over s[31:0]
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

    localparam logic [7:0] ALPHA   = 8'd26;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_Z = 8'h5A;
    localparam logic [7:0] ASCII_a = 8'h61;

    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } dec_t;

    // Standard step shared with the encryptor: new bit enters at the LSB.
    function automatic logic [31:0] LFSR_STEP(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    // key is at most 31, so one conditional subtract gives key % 26; the letter
    // offset plus 26 minus k stays below 52, so one more subtract finishes the mod.
    function automatic dec_t decrypt(input logic [7:0] c, input logic [4:0] key);
        logic [7:0] k;
        logic [7:0] v;
        dec_t       r;
        k = {3'b000, key};
        if (k >= ALPHA) k = k - ALPHA;
        if ((c >= ASCII_A) && (c <= ASCII_Z)) begin
            v = (c - ASCII_A) + ALPHA - k;
            if (v >= ALPHA) v = v - ALPHA;
            r.data = v + ASCII_a;
            r.err  = 1'b0;
        end else begin
            r.data = c;
            r.err  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ceas_decip_stream_if.sv
// Ciphertext-in / plaintext-out stream bundle for the Caesar decipher stage.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; master drives the input stream and out_ready.
// Signals: in_data/in_valid/in_last/in_ready (input stream), out_data/out_valid/out_last/out_err/out_ready (output stream).
interface ceas_decip_stream_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_err;
    logic       out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_err
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_err
    );
endinterface

// File: rtl/lfsr32_en.sv
// 32-bit Fibonacci LFSR with synchronous load and step enable.
// Latency: q updates on the clock edge after load/en.
// Backpressure: n/a; holds its state whenever en is low.
// Ports: clk, rst (sync, active-high), load/seed (load wins over en), en (step once), q (state).
module lfsr32_en
    import ceas_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        en,
    output logic [31:0] q
);

    logic [31:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_RESET;
        end else if (load) begin
            lfsr_q <= seed;
        end else if (en) begin
            lfsr_q <= LFSR_STEP(lfsr_q);
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/ceas_decip_stream.sv
// Caesar decipher stage: 4-byte seed header per frame, then uppercase ciphertext -> lowercase plaintext.
// Latency: 1 cycle from data-byte acceptance to out_valid; header bytes produce no output.
// Backpressure: registered output; in_ready drops in DATA while a held byte is not being drained.
// Ports: clk, rst (sync, active-high), s (slave stream), byte_cnt (data bytes this frame), err_cnt (non-letters since reset).
module ceas_decip_stream
    import ceas_pkg::*;
#(
    parameter int KEY_LSB = 13,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ceas_decip_stream_if.slave    s,
    output logic [CNT_W-1:0]      byte_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    state_e            state_q, state_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    // Only the first three header bytes need storing; the fourth arrives with the load.
    logic [23:0]       seed_q, seed_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [31:0]       lfsr_q;
    logic [31:0]       hdr_word;
    logic [31:0]       lfsr_seed;
    logic              lfsr_load;
    logic              lfsr_en;
    logic              in_acc;
    dec_t              dec;

    // Bits of the LFSR outside the key field are not read by this stage.
    logic              unused_lfsr;
    assign unused_lfsr = ^lfsr_q;

    assign s.in_ready = (state_q == HDR) || !out_valid_q || s.out_ready;
    assign in_acc     = s.in_valid && s.in_ready;

    assign hdr_word   = {seed_q, s.in_data};
    // An all-zero seed would lock the LFSR at zero forever.
    assign lfsr_seed  = (hdr_word == 32'h0) ? LFSR_RESET : hdr_word;

    assign dec        = decrypt(s.in_data, lfsr_q[KEY_LSB+4:KEY_LSB]);

    lfsr32_en u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (lfsr_seed),
        .en   (lfsr_en),
        .q    (lfsr_q)
    );

    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        seed_d      = seed_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        byte_cnt_d  = byte_cnt_q;
        err_cnt_d   = err_cnt_q;
        lfsr_load   = 1'b0;
        lfsr_en     = 1'b0;

        // Drain first; a data-byte load below overrides it for full throughput.
        if (s.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_acc) begin
            case (state_q)
                HDR: begin
                    seed_d    = {seed_q[15:0], s.in_data};
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'd3) begin
                        lfsr_load  = 1'b1;
                        byte_cnt_d = '0;
                        hdr_idx_d  = 2'd0;
                        state_d    = DATA;
                    end
                end
                DATA: begin
                    out_valid_d = 1'b1;
                    out_data_d  = dec.data;
                    out_err_d   = dec.err;
                    out_last_d  = s.in_last;
                    // Step on every data byte, letter or not, to stay in lockstep with the encryptor.
                    lfsr_en     = 1'b1;
                    if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (dec.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
                    if (s.in_last) begin
                        state_d   = HDR;
                        hdr_idx_d = 2'd0;
                    end
                end
                default: state_d = HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            hdr_idx_q   <= 2'd0;
            seed_q      <= 24'h0;
            out_data_q  <= 8'h0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            byte_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            seed_q      <= seed_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            byte_cnt_q  <= byte_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign s.out_data  = out_data_q;
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.out_err   = out_err_q;
    assign byte_cnt    = byte_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ceas_decip_stream.sv
// Bench for ceas_decip_stream: vector table of single-byte frames, then multi-cycle sequences.
// Expected output beats are queued when the matching input byte is accepted and popped when the DUT emits.
module tb_ceas_decip_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] byte_cnt;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    ceas_decip_stream_if bus();

    ceas_decip_stream #(.KEY_LSB(13), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (bus),
        .byte_cnt (byte_cnt),
        .err_cnt  (err_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic [31:0] seed;
        logic [7:0]  c;
        logic [7:0]  exp_d;
        logic        exp_err;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    exp_t        sb[$];
    logic [31:0] m_lfsr;
    int          m_err    = 0;
    logic        bp_en    = 1'b0;
    vec_t        vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Output monitor: a beat transfers on the next rising edge when valid && ready now.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h expected=none", bus.out_data);
            end else begin
                e = sb.pop_front();
                check("out_beat{data,last,err}", {22'h0, bus.out_data, bus.out_last, bus.out_err},
                      {22'h0, e.data, e.last, e.err});
            end
        end
    end

    // Random output backpressure, changed well clear of both clock edges.
    always @(posedge clk) begin
        #2;
        if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
    end

    function automatic logic [31:0] m_step(input logic [31:0] st);
        return {st[30:0], st[31] ^ st[21] ^ st[1] ^ st[0]};
    endfunction

    function automatic int m_key(input logic [31:0] st);
        logic [4:0] kf;
        kf = st[17:13];
        return int'(kf) % 26;
    endfunction

    // Present one byte; returns just after the rising edge that accepted it.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=in_ready_low expected=accept");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_hdr(input logic [31:0] seed);
        for (int i = 0; i < 4; i++) send(seed[31-8*i -: 8], 1'b0);
        m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
    endtask

    // Encrypt plaintext letter index p with the model key, expect the lowercase letter back.
    task automatic send_plain(input int p, input logic last);
        int         k;
        logic [7:0] c;
        k = m_key(m_lfsr);
        c = 8'h41 + 8'((p + k) % 26);
        sb.push_back('{data: 8'h61 + 8'(p), last: last, err: 1'b0});
        send(c, last);
        m_lfsr = m_step(m_lfsr);
    endtask

    task automatic send_nonalpha(input logic [7:0] c, input logic last);
        sb.push_back('{data: c, last: last, err: 1'b1});
        m_err++;
        send(c, last);
        m_lfsr = m_step(m_lfsr);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bp_en         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0;
        int         k;
        logic [7:0] c2;
        exp_t       hold;

        vecs[0] = '{32'h0000_2000, 8'h42, 8'h61, 1'b0};  // key 1: 'B' -> 'a'
        vecs[1] = '{32'h0001_A000, 8'h4E, 8'h61, 1'b0};  // key 13: 'N' -> 'a'
        vecs[2] = '{32'h0003_E000, 8'h41, 8'h76, 1'b0};  // key 31%26=5: 'A' -> 'v'
        vecs[3] = '{32'h0000_0000, 8'h5A, 8'h7A, 1'b0};  // zero seed -> 1, key 0: 'Z' -> 'z'
        vecs[4] = '{32'h0000_6000, 8'h43, 8'h7A, 1'b0};  // key 3: 'C' -> 'z'
        vecs[5] = '{32'h0001_4000, 8'h4D, 8'h63, 1'b0};  // key 10: 'M' -> 'c'
        vecs[6] = '{32'h0003_2000, 8'h41, 8'h62, 1'b0};  // key 25: 'A' -> 'b'
        vecs[7] = '{32'h0000_2000, 8'h40, 8'h40, 1'b1};  // '@' just below 'A'
        vecs[8] = '{32'h0000_2000, 8'h5B, 8'h5B, 1'b1};  // '[' just above 'Z'
        vecs[9] = '{32'h0000_2000, 8'h61, 8'h61, 1'b1};  // lowercase passes through

        bus.in_data   = 8'h0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        idle(2);

        // Single-byte frames from the vector table
        for (int i = 0; i < 10; i++) begin
            send_hdr(vecs[i].seed);
            sb.push_back('{data: vecs[i].exp_d, last: 1'b1, err: vecs[i].exp_err});
            if (vecs[i].exp_err) m_err++;
            send(vecs[i].c, 1'b1);
            drain();
            check("vec_byte_cnt", byte_cnt, 1);
            check("vec_err_cnt", err_cnt, 32'(m_err));
        end

        // Non-letters mid-frame must still step the key sequence
        send_hdr(32'hDEAD_BEEF);
        send_plain(7, 1'b0);
        send_nonalpha(8'h20, 1'b0);
        send_plain(8, 1'b0);
        send_nonalpha(8'h7B, 1'b0);
        send_plain(25, 1'b1);
        drain();
        check("mid_err_cnt", err_cnt, 32'(m_err));
        check("mid_byte_cnt", byte_cnt, 5);

        // Output hold under backpressure, then full-rate streaming
        send_hdr(32'h1234_5678);
        bus.out_ready = 1'b0;
        send_plain(3, 1'b0);
        check("hold_valid_set", bus.out_valid, 1);
        hold = '{data: bus.out_data, last: bus.out_last, err: bus.out_err};
        k  = m_key(m_lfsr);
        c2 = 8'h41 + 8'((11 + k) % 26);
        sb.push_back('{data: 8'h6C, last: 1'b0, err: 1'b0});
        m_lfsr = m_step(m_lfsr);
        bus.in_data  = c2;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_out_stable", {22'h0, bus.out_data, bus.out_last, bus.out_err},
                  {22'h0, hold.data, hold.last, hold.err});
            check("hold_out_valid", bus.out_valid, 1);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(c2, 1'b0);
        t0 = cyc;
        for (int i = 0; i < 8; i++) send_plain(i * 3, i == 7);
        check("throughput_cycles", 32'(cyc - t0), 8);
        drain();
        check("hold_byte_cnt", byte_cnt, 10);

        // Zero seed, long frame under random backpressure
        bp_en = 1'b1;
        send_hdr(32'h0000_0000);
        for (int i = 0; i < 64; i++) send_plain($urandom_range(0, 25), i == 63);
        drain();
        check("long_byte_cnt", byte_cnt, 64);

        // Reset in the middle of a header with a held output byte
        send_hdr(32'h0000_2000);
        bus.out_ready = 1'b0;
        send_plain(4, 1'b1);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        check("pre_rst_valid", bus.out_valid, 1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        check("midrst_out_last", bus.out_last, 0);
        check("midrst_byte_cnt", byte_cnt, 0);
        check("midrst_err_cnt", err_cnt, 0);
        rst           = 1'b0;
        m_err         = 0;
        bus.out_ready = 1'b1;
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h20, 1'b0);
        idle(3);
        check("no_out_before_hdr", bus.out_valid, 0);
        send(8'h00, 1'b0);
        sb.push_back('{data: 8'h61, last: 1'b1, err: 1'b0});
        send(8'h42, 1'b1);
        drain();
        check("post_rst_byte_cnt", byte_cnt, 1);
        check("post_rst_err_cnt", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
